// File: rtl/pipe_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_int_ctrl_if -- pipeline <-> interrupt controller signal bundle.
//
// Inputs to the controller:
//   irq[2:0]     external interrupt lines, level; irq[2] highest priority
//   maskWE       write enable for the mask register
//   maskIn[2:0]  new mask value, 1 = source enabled
//   validEX      EX stage holds a real (non-bubble) instruction
//   pcEX[31:0]   PC of the EX-stage instruction
//   eretEX       EX instruction is ERET
//   stallIn      load-use stall from the hazard unit this cycle
//   flushIn      jump/taken-branch flush from the hazard unit this cycle
// Outputs from the controller:
//   intFlush     one-cycle pulse: squash IF/ID/EX and redirect PC
//   redirectPC   target PC, valid while intFlush=1, else 0
//   epc          saved return PC
//   inISR        handler in progress
//   pending[2:0] latched, not-yet-taken requests
// -----------------------------------------------------------------------------
interface pipe_int_ctrl_if;
   logic [2:0]  irq;
   logic        maskWE;
   logic [2:0]  maskIn;
   logic        validEX;
   logic [31:0] pcEX;
   logic        eretEX;
   logic        stallIn;
   logic        flushIn;
   logic        intFlush;
   logic [31:0] redirectPC;
   logic [31:0] epc;
   logic        inISR;
   logic [2:0]  pending;

   // Pipeline / hazard-unit side.
   modport master (
      output irq, maskWE, maskIn, validEX, pcEX, eretEX, stallIn, flushIn,
      input  intFlush, redirectPC, epc, inISR, pending
   );

   // Interrupt controller side.
   modport slave (
      input  irq, maskWE, maskIn, validEX, pcEX, eretEX, stallIn, flushIn,
      output intFlush, redirectPC, epc, inISR, pending
   );
endinterface

// File: rtl/pipe_int_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_int_ctrl -- pipelined-CPU interrupt controller.
//
// Latches rising edges of three level interrupt lines, waits for a safe EX
// slot (real instruction, no stall, no hazard flush), then issues a one-cycle
// flush/redirect to the handler vector 0x100 + 0x20*source. ERET in EX while
// the handler runs issues a second one-cycle flush/redirect back to epc.
// No nesting: requests arriving in the handler stay pending.
//
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_int_ctrl_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module pipe_int_ctrl (
   input  logic             clk,
   input  logic             rst_n,
   pipe_int_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_TAKE,
      S_ISR,
      S_RET
   } state_t;

   localparam logic [31:0] VECTOR_BASE = 32'h0000_0100;

   state_t      state_q, state_d;
   logic [2:0]  irq_q;
   logic [2:0]  pending_q, pending_d;
   logic [2:0]  mask_q;
   logic [1:0]  src_q, src_d;
   logic [31:0] epc_q, epc_d;

   logic [2:0]  rise;
   logic [2:0]  enabled;
   logic [2:0]  take_clr;
   logic [1:0]  winner;
   logic        safe_slot;
   logic        eret_ok;

   assign rise      = bus.irq & ~irq_q;
   assign enabled   = pending_q & mask_q;
   assign safe_slot = bus.validEX & ~bus.stallIn & ~bus.flushIn;
   assign eret_ok   = bus.eretEX & bus.validEX & ~bus.stallIn;

   // Highest enabled pending source wins.
   always_comb begin
      if (enabled[2])      winner = 2'd2;
      else if (enabled[1]) winner = 2'd1;
      else                 winner = 2'd0;
   end

   // NOTE: every signal assigned in this block gets a default first, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      epc_d    = epc_q;
      take_clr = 3'b000;
      case (state_q)
         S_IDLE: if (enabled != 3'b000) state_d = S_WAIT;
         S_WAIT: begin
            if (enabled == 3'b000) begin
               state_d = S_IDLE;
            end else if (safe_slot) begin
               state_d  = S_TAKE;
               src_d    = winner;
               epc_d    = bus.pcEX;
               take_clr = 3'b001 << winner;
            end
         end
         S_TAKE: state_d = S_ISR;
         S_ISR:  if (eret_ok) state_d = S_RET;
         S_RET:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The take clear is applied before the new edge is merged, so an edge on
   // the very source being taken survives.
   assign pending_d = (pending_q & ~take_clr) | rise;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         irq_q     <= 3'b000;
         pending_q <= 3'b000;
         mask_q    <= 3'b111;
         src_q     <= 2'd0;
         epc_q     <= 32'h0;
      end else begin
         state_q   <= state_d;
         irq_q     <= bus.irq;
         pending_q <= pending_d;
         src_q     <= src_d;
         epc_q     <= epc_d;
         if (bus.maskWE) mask_q <= bus.maskIn;
      end
   end

   // Outputs decode straight from state, so reset clears them without a clock.
   always_comb begin
      bus.intFlush   = 1'b0;
      bus.redirectPC = 32'h0;
      case (state_q)
         S_TAKE: begin
            bus.intFlush   = 1'b1;
            bus.redirectPC = VECTOR_BASE + {25'd0, src_q, 5'd0};
         end
         S_RET: begin
            bus.intFlush   = 1'b1;
            bus.redirectPC = epc_q;
         end
         default: ;
      endcase
   end

   assign bus.inISR   = (state_q == S_ISR);
   assign bus.epc     = epc_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_int_ctrl -- scoreboard bench for pipe_int_ctrl.
// A reference model steps once per rising edge and queues every redirect
// target the controller must emit; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_int_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pipe_int_ctrl_if bus ();

   pipe_int_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural view: a request is "armed" once enabled and pending, is
   // accepted in the first safe slot, and each accepted request produces a
   // handler-entry redirect next cycle, later an ERET redirect to its PC.
   logic [31:0] sb_q[$];
   bit   [2:0]  m_pend, m_mask, m_irq_prev;
   bit          m_armed, m_entering, m_in_isr, m_returning;
   logic [31:0] m_epc;
   int          m_src;

   task automatic model_reset();
      m_pend = 0; m_mask = 3'b111; m_irq_prev = 0;
      m_armed = 0; m_entering = 0; m_in_isr = 0; m_returning = 0;
      m_epc = 0; m_src = 0;
      sb_q.delete();
   endtask

   function automatic int top_source(input bit [2:0] v);
      int r = -1;
      for (int i = 0; i < 3; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_step();
      bit [2:0] en;
      bit [2:0] edges;
      bit       safe;
      en    = m_pend & m_mask;
      edges = bus.irq & ~m_irq_prev;
      safe  = bus.validEX && !bus.stallIn && !bus.flushIn;
      if (m_entering) begin
         m_entering = 0; m_in_isr = 1;
      end else if (m_returning) begin
         m_returning = 0;
      end else if (m_in_isr) begin
         if (bus.eretEX && bus.validEX && !bus.stallIn) begin
            m_in_isr = 0; m_returning = 1;
         end
      end else if (m_armed) begin
         if (en == 0) m_armed = 0;
         else if (safe) begin
            m_src = top_source(en);
            m_epc = bus.pcEX;
            m_pend[m_src] = 1'b0;
            m_armed = 0; m_entering = 1;
         end
      end else if (en != 0) begin
         m_armed = 1;
      end
      m_pend     = m_pend | edges;
      if (bus.maskWE) m_mask = bus.maskIn;
      m_irq_prev = bus.irq;
      if (m_entering)  sb_q.push_back(32'h100 + 32'h20 * m_src);
      if (m_returning) sb_q.push_back(m_epc);
   endtask

   always @(posedge clk) if (rst_n) model_step();
   always @(negedge rst_n) model_reset();

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [31:0] exp_pc;
      check("intFlush", {31'd0, bus.intFlush}, {31'd0, (sb_q.size() != 0)});
      if (bus.intFlush && sb_q.size() != 0) begin
         exp_pc = sb_q.pop_front();
         check("redirectPC", bus.redirectPC, exp_pc);
      end else begin
         if (sb_q.size() != 0) void'(sb_q.pop_front());
         check("redirectPC_idle", bus.redirectPC, 32'h0);
      end
      check("pending", {29'd0, bus.pending}, {29'd0, m_pend});
      check("inISR", {31'd0, bus.inISR}, {31'd0, m_in_isr});
      check("epc", bus.epc, m_epc);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.irq = 0; bus.maskWE = 0; bus.maskIn = 0; bus.validEX = 1;
      bus.pcEX = 32'h40; bus.eretEX = 0; bus.stallIn = 0; bus.flushIn = 0;
   endtask

   task automatic eret_pulse();
      bus.eretEX = 1; bus.validEX = 1; bus.stallIn = 0;
      cyc(1);
      bus.eretEX = 0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_pending", {29'd0, bus.pending}, 32'h0);
      check("rst_inISR", {31'd0, bus.inISR}, 32'h0);
      check("rst_intFlush", {31'd0, bus.intFlush}, 32'h0);
      check("rst_redirectPC", bus.redirectPC, 32'h0);
      check("rst_epc", bus.epc, 32'h0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      quiet();
      model_reset();
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Single source, permanently safe slot.
      bus.irq = 3'b010; bus.pcEX = 32'h40;
      cyc(6);
      eret_pulse();
      bus.irq = 3'b000;
      cyc(4);

      // Two sources together: src2 first, src0 after ERET.
      bus.irq = 3'b101; bus.pcEX = 32'h200;
      cyc(6);
      bus.pcEX = 32'h300;
      eret_pulse();
      cyc(8);
      eret_pulse();
      bus.irq = 3'b000;
      cyc(4);

      // Unsafe slots delay the take.
      bus.stallIn = 1;
      bus.irq = 3'b010;
      cyc(3);
      bus.stallIn = 0; bus.flushIn = 1;
      cyc(1);
      bus.flushIn = 0; bus.pcEX = 32'h88;
      cyc(4);
      eret_pulse();
      bus.irq = 3'b000;
      cyc(4);

      // Masked source stays pending until re-enabled.
      bus.maskWE = 1; bus.maskIn = 3'b101;
      cyc(1);
      bus.maskWE = 0;
      bus.irq = 3'b010;
      cyc(6);
      bus.maskWE = 1; bus.maskIn = 3'b111;
      cyc(1);
      bus.maskWE = 0;
      cyc(6);
      eret_pulse();
      bus.irq = 3'b000;
      cyc(4);

      // Reset inside the handler, then a stray ERET.
      bus.irq = 3'b100;
      cyc(6);
      pulse_reset();
      eret_pulse();
      bus.irq = 3'b000;
      cyc(4);

      // Randomised traffic with one mid-run reset.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(7) == 0) bus.irq[$urandom_range(2)] ^= 1'b1;
         bus.validEX = ($urandom_range(99) < 85);
         bus.stallIn = ($urandom_range(5) == 0);
         bus.flushIn = ($urandom_range(7) == 0);
         bus.eretEX  = ($urandom_range(5) == 0);
         bus.pcEX    = $urandom() & 32'hFFFF_FFFC;
         bus.maskWE  = ($urandom_range(39) == 0);
         bus.maskIn  = 3'($urandom_range(7));
         if (c == 700) pulse_reset();
         else cyc(1);
      end
      quiet();
      cyc(10);
      eret_pulse();
      cyc(5);
      check("scoreboard_drained", sb_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
